instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pc_control  input  3  next-PC select from the decoder: 000 sequential, 001 jump, 010 register jump, 011 branch, 100-111 treated as sequential.
REQ-005 rs_data  input  32  register-file rs value; the target for pc_control 010.
REQ-006 stall  input  1  holds the current instruction in EXEC.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  instruction-memory word address (byte address, low 2 bits 00).
REQ-009 imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  instruction presented to the decoder.
REQ-012 instr_valid  output  1  instr is valid and pc_control is being sampled.
REQ-013 pc  output  32  address of the instruction on instr.
REQ-014 pc_plus4  output  32  pc+4; the link value for JAL/JALR.
REQ-015 fetch_fault  output  1  misaligned-target fault; exists only under REQ-032.

Function
REQ-016 The FSM SHALL have three states: FETCH, EXEC and HALT; it enters FETCH on reset release.
REQ-017 FETCH: imem_req=1 and imem_addr=pc, both stable until imem_ack; on ack, imem_rdata is latched into instr and the next state is EXEC.
REQ-018 imem_ack SHALL be ignored outside FETCH.
REQ-019 EXEC: instr_valid=1 and imem_req=0.
- stall=1: remain in EXEC with instr and pc unchanged.
- stall=0: pc loads next_pc at the edge, then FETCH.
REQ-020 Latency: ack sampled at edge N -> instr_valid=1 in cycle N+1. With stall=0, the next imem_req for the new pc is in cycle N+2.
REQ-021 next_pc is selected by pc_control:
- 000: pc_plus4.
- 001: {pc_plus4[31:28], instr[25:0], 2'b00}.
- 010: rs_data.
- 011: pc_plus4 + (sign-extended instr[15:0] << 2).
- others: pc_plus4.
REQ-022 All PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 SHALL be silent.
REQ-023 pc_control and rs_data SHALL be sampled only at the EXEC edge where stall=0.
REQ-024 pc_plus4 SHALL be combinational pc+32'd4 at all times.
REQ-025 HALT is terminal: imem_req=0 and instr_valid=0 until reset.

Reset
REQ-026 Assertion of rst_n=0 at any time, including mid-FETCH with a request outstanding, SHALL immediately force FETCH state, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 and fetch_fault=0.
REQ-027 imem_req SHALL be 0 during reset and rise in the first clock cycle after rst_n deasserts.
REQ-028 An imem_ack arriving during reset SHALL be discarded.

Configuration
REQ-029 The macro FETCH_ALIGN_CHECK_EN selects the misaligned-target behaviour.
REQ-030 Without FETCH_ALIGN_CHECK_EN, next_pc[1:0] SHALL be forced to 00 and no fault is possible.
REQ-031 With FETCH_ALIGN_CHECK_EN, a next_pc with [1:0] != 00 (reachable only via 010) SHALL:
- leave pc unchanged;
- set fetch_fault=1 (sticky);
- enter HALT.
REQ-032 The fetch_fault port SHALL exist only when FETCH_ALIGN_CHECK_EN is defined.

Verification
REQ-033 Reset release, RESET_PC=0, ack after 2 wait cycles, rdata=32'h2008_0005 -> imem_addr=0 held for 3 cycles; instr=32'h2008_0005 with instr_valid=1 in the cycle after ack; next imem_addr=4.
REQ-034 pc=32'h0000_0010, instr=32'h0800_0100, pc_control=001 -> next imem_addr=32'h0000_0400; pc_plus4 before the jump=32'h0000_0014.
REQ-035 pc=32'h0000_0020, instr imm=16'hFFFE, pc_control=011 -> next pc=32'h0000_001C; same with pc_control=000 -> 32'h0000_0024.
REQ-036 stall=1 for 4 EXEC cycles with pc_control=010, rs_data=32'h0000_0100 -> instr/pc held, no imem_req; one cycle after stall drops, imem_addr=32'h0000_0100.
REQ-037 rst_n=0 pulse while imem_req=1 and an ack arrives in the same cycle -> instr stays 0, pc=RESET_PC, imem_req=0 during reset, then refetch from RESET_PC.
REQ-038 With FETCH_ALIGN_CHECK_EN, pc_control=010 and rs_data=32'h0000_0102 -> fetch_fault=1, HALT, imem_req stays 0. Without the macro -> imem_addr=32'h0000_0100.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/EXEC/HALT sequencer with PC select and imem read port.
// Latency: ack at edge N -> instr_valid in cycle N+1 -> next imem_req in cycle N+2 when stall=0.
// Backpressure: stall holds instr/pc in EXEC; imem_req/imem_addr are held until imem_ack.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pc_control, rs_data    next-PC select and register target, sampled at the EXEC edge with stall=0
//   stall                  holds the current instruction in EXEC
//   imem_req/addr/ack/rdata instruction memory read handshake (rdata valid with ack)
//   instr, instr_valid, pc, pc_plus4  decoder-facing instruction, its address and link value
//   fetch_fault            sticky misaligned-target fault (only with FETCH_ALIGN_CHECK_EN)
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned targets instead of
// silently clearing next_pc[1:0].
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_control,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  // Clear during reset and set at the first edge afterwards, so the request
  // stays low throughout reset even though the state register sits in FETCH.
  logic        armed_q;
  logic [31:0] next_pc;
  logic [31:0] br_off;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
  assign fetch_fault = fault_q;
`endif

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign imem_addr   = pc_q;
  assign imem_req    = armed_q && (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);

  // Sign-extended word offset of the branch immediate, already scaled by 4.
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_control)
      3'b001:  next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      3'b010:  next_pc = rs_data;
      3'b011:  next_pc = pc_plus4 + br_off;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (armed_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
`else
          // Only a register jump can produce low bits; drop them.
          pc_d    = next_pc & ~32'd3;
          state_d = FETCH;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      armed_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      armed_q <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized fetch/exec traffic
// checked against an arithmetic next-PC model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [2:0]  pc_control;
  logic [31:0] rs_data;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int n_cmp;
  int n_bad;
  logic [31:0] m_pc;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_control  (pc_control),
    .rs_data     (rs_data),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next PC from the selection rules, written as plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic [2:0] ctrl, input logic [31:0] rs);
    logic [31:0] seq;
    logic [31:0] r;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ins[15:0]));
    case (ctrl)
      3'd1:    r = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      3'd2:    r = rs;
      3'd3:    r = seq + 32'(off * 4);
      default: r = seq;
    endcase
`ifndef FETCH_ALIGN_CHECK_EN
    r = r & 32'hFFFF_FFFC;
`endif
    return r;
  endfunction

  // Memory responder: waits (bounded) for a request, holds off 'waits' cycles
  // watching the address, then returns 'data' with a single-cycle ack.
  // Returns at the falling edge of the cycle after the ack.
  task automatic serve_fetch(input logic [31:0] data, input int waits,
                             output logic [31:0] addr, output bit stable, output bit to);
    int cnt;
    cnt = 0; to = 1'b0; stable = 1'b1; addr = 32'd0;
    while (imem_req !== 1'b1 && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    if (imem_req !== 1'b1) begin
      to = 1'b1;
      return;
    end
    addr = imem_addr;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== addr) stable = 1'b0;
    end
    imem_rdata = data;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Leave EXEC with the given select; afterwards scramble the select inputs,
  // which must not be sampled again until the next EXEC.
  task automatic release_exec(input logic [2:0] ctrl, input logic [31:0] rs);
    pc_control = ctrl;
    rs_data    = rs;
    stall      = 1'b0;
    @(negedge clk);
    pc_control = 3'($urandom);
    rs_data    = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    stall = 1'b0; pc_control = 3'd0; rs_data = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    n_cmp++; if (pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
    n_cmp++; if (instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
    n_cmp++; if (pc_plus4 !== RESET_PC + 32'd4) begin n_bad++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4, RESET_PC + 32'd4); end
`ifdef FETCH_ALIGN_CHECK_EN
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
`endif
  endtask

  task automatic test_first_fetch();
    logic [31:0] a; bit st, to;
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_bad++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RESET_PC); end
    serve_fetch(32'h2008_0005, 2, a, st, to);
    n_cmp++; if (to || !st || a !== 32'd0) begin n_bad++; $display("FAIL first_hold got=%h stable=%0d to=%0d exp=0 stable", a, st, to); end
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005) begin n_bad++; $display("FAIL first_instr got=%b/%h exp=1/20080005", instr_valid, instr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL first_req_drop got=%b exp=0", imem_req); end
    release_exec(3'd0, $urandom);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin n_bad++; $display("FAIL first_next got=%b/%h exp=1/00000004", imem_req, imem_addr); end
    m_pc = 32'd4;
  endtask

  task automatic test_jump();
    logic [31:0] a; bit st, to;
    serve_fetch($urandom, 0, a, st, to);
    n_cmp++; if (to || a !== m_pc) begin n_bad++; $display("FAIL jump_pre got=%h exp=%h", a, m_pc); end
    release_exec(3'd2, 32'h0000_0010);
    serve_fetch(32'h0800_0100, 1, a, st, to);
    n_cmp++; if (to || a !== 32'h10) begin n_bad++; $display("FAIL jump_jr got=%h exp=00000010", a); end
    n_cmp++; if (pc !== 32'h10 || pc_plus4 !== 32'h14) begin n_bad++; $display("FAIL jump_pc4 got=%h/%h exp=00000010/00000014", pc, pc_plus4); end
    release_exec(3'd1, $urandom);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_bad++; $display("FAIL jump_target got=%h exp=00000400", imem_addr); end
    m_pc = 32'h400;
  endtask

  task automatic test_branch();
    logic [31:0] a; bit st, to;
    serve_fetch($urandom, 0, a, st, to);
    release_exec(3'd2, 32'h20);
    serve_fetch(32'hABCD_FFFE, 0, a, st, to);
    n_cmp++; if (to || a !== 32'h20) begin n_bad++; $display("FAIL br_setup got=%h exp=00000020", a); end
    release_exec(3'd3, $urandom);
    n_cmp++; if (imem_addr !== 32'h1C) begin n_bad++; $display("FAIL br_taken got=%h exp=0000001c", imem_addr); end
    serve_fetch($urandom, 1, a, st, to);
    release_exec(3'd2, 32'h20);
    serve_fetch(32'hABCD_FFFE, 0, a, st, to);
    release_exec(3'd0, $urandom);
    n_cmp++; if (imem_addr !== 32'h24) begin n_bad++; $display("FAIL br_seq got=%h exp=00000024", imem_addr); end
    m_pc = 32'h24;
  endtask

  task automatic test_stall();
    logic [31:0] a, d; bit st, to;
    d = $urandom;
    serve_fetch(d, 0, a, st, to);
    n_cmp++; if (to || a !== m_pc) begin n_bad++; $display("FAIL stall_pre got=%h exp=%h", a, m_pc); end
    stall = 1'b1; pc_control = 3'd2; rs_data = 32'h100;
    imem_ack = 1'b1; imem_rdata = ~d;  // stray ack must be ignored in EXEC
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== d || pc !== m_pc) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] got v=%b req=%b instr=%h pc=%h exp v=1 req=0 instr=%h pc=%h",
                 i, instr_valid, imem_req, instr, pc, d, m_pc);
      end
    end
    imem_ack = 1'b0; stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL stall_release got=%b/%h exp=1/00000100", imem_req, imem_addr); end
    m_pc = 32'h100;
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a, d; bit st, to;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got=%b exp=1", imem_req); end
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || pc !== RESET_PC || instr !== 32'd0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_async got req=%b pc=%h instr=%h v=%b exp 0/%h/0/0", imem_req, pc, instr, instr_valid, RESET_PC);
    end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0 || instr !== 32'd0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_ack_drop got req=%b instr=%h v=%b exp 0/0/0", imem_req, instr, instr_valid);
    end
    imem_ack = 1'b0; rst_n = 1'b1;
    d = $urandom;
    serve_fetch(d, 1, a, st, to);
    n_cmp++; if (to || a !== RESET_PC || instr !== d) begin n_bad++; $display("FAIL rmid_refetch got=%h/%h exp=%h/%h", a, instr, RESET_PC, d); end
    m_pc = RESET_PC;
    release_exec(3'd0, $urandom);
    m_pc = m_pc + 32'd4;
  endtask

  task automatic test_wrap();
    logic [31:0] a; bit st, to;
    serve_fetch($urandom, 0, a, st, to);
    release_exec(3'd2, 32'hFFFF_FFFC);
    serve_fetch($urandom, 0, a, st, to);
    n_cmp++; if (to || a !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin n_bad++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/00000000", a, pc_plus4); end
    release_exec(3'd0, $urandom);
    n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL wrap_seq got=%h exp=00000000", imem_addr); end
    m_pc = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] a, ins, rs, exp; logic [2:0] ctrl; bit st, to; int k;
    for (int it = 0; it < 60; it++) begin
      ins = $urandom;
      serve_fetch(ins, $urandom_range(0, 3), a, st, to);
      n_cmp++;
      if (to || !st || a !== m_pc || instr_valid !== 1'b1 || instr !== ins || pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        n_bad++;
        $display("FAIL rand_fetch[%0d] got addr=%h instr=%h pc=%h pc4=%h v=%b exp addr=%h instr=%h", it, a, instr, pc, pc_plus4, instr_valid, m_pc, ins);
      end
      k = $urandom_range(0, 3);
      for (int s = 0; s < k; s++) begin
        stall = 1'b1; pc_control = 3'($urandom); rs_data = $urandom;
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        @(negedge clk);
        n_cmp++;
        if (instr !== ins || pc !== m_pc || imem_req !== 1'b0) begin
          n_bad++; $display("FAIL rand_stall[%0d] got instr=%h pc=%h req=%b exp %h/%h/0", it, instr, pc, imem_req, ins, m_pc);
        end
      end
      imem_ack = 1'b0;
      ctrl = 3'($urandom);
      rs   = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      rs[1:0] = 2'b00;
`endif
      exp = ref_next(m_pc, ins, ctrl, rs);
      release_exec(ctrl, rs);
      m_pc = exp;
    end
  endtask

  task automatic test_align();
    logic [31:0] a; bit st, to;
    serve_fetch($urandom, 0, a, st, to);
    n_cmp++; if (to || a !== m_pc) begin n_bad++; $display("FAIL align_pre got=%h exp=%h", a, m_pc); end
    release_exec(3'd2, 32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== m_pc) begin
        n_bad++; $display("FAIL align_halt[%0d] got fault=%b req=%b v=%b pc=%h exp 1/0/0/%h", i, fetch_fault, imem_req, instr_valid, pc, m_pc);
      end
      imem_ack = 1'($urandom);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fetch_fault !== 1'b0 || pc !== RESET_PC) begin n_bad++; $display("FAIL align_clear got=%b/%h exp=0/%h", fetch_fault, pc, RESET_PC); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`else
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL align_mask got=%b/%h exp=1/00000100", imem_req, imem_addr); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_pc = RESET_PC;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; pc_control = 3'd0; rs_data = 32'd0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_jump();
    test_branch();
    test_stall();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
